// File: rtl/bft_pkt_pkg.sv
// BFT leaf packet field layout, packetizer FSM states and credit constants.
// Shared by the stream packetizer and its credit counter.
package bft_pkt_pkg;

    localparam int PACKET_BITS        = 49;
    localparam int PAYLOAD_BITS       = 32;
    localparam int NUM_LEAF_BITS      = 4;
    localparam int NUM_PORT_BITS      = 4;
    localparam int NUM_ADDR_BITS      = 7;
    localparam int NUM_BRAM_ADDR_BITS = 7;

    localparam int VALID_BIT       = 48;
    localparam int LEAF_MSB        = 47;
    localparam int LEAF_LSB        = 44;
    localparam int PORT_MSB        = 43;
    localparam int PORT_LSB        = 40;
    localparam int ADDR_MSB        = 39;
    localparam int ADDR_LSB        = 33;
    localparam int CREDIT_FLAG_BIT = 32;

    localparam int CREDIT_BITS = 8;
    localparam logic [CREDIT_BITS-1:0] INIT_CREDITS = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SENT   = 2'd1,
        ST_RESEND = 2'd2,
        ST_STALL  = 2'd3
    } pkt_state_e;

    function automatic logic [PACKET_BITS-1:0] make_data_pkt(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        make_data_pkt = {1'b1, leaf, port, addr, 1'b0, payload};
    endfunction

endpackage

// File: rtl/bft_credit_counter.sv
// Receiver freespace credit counter: net add/decrement, saturating at INIT_CREDITS.
// Latency: update visible the cycle after dec/inc. Backpressure: has_credit gates senders.
// Decrement is only ever requested while has_credit is high, so no underflow.
module bft_credit_counter
    import bft_pkt_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dec,
    input  logic                   inc_vld,
    input  logic [CREDIT_BITS-1:0] inc,
    output logic [CREDIT_BITS-1:0] credits,
    output logic                   has_credit
);

    logic [CREDIT_BITS-1:0] credits_q, credits_d;
    logic [CREDIT_BITS+1:0] sum;

    always_comb begin
        sum = {2'b00, credits_q}
            + (inc_vld ? {2'b00, inc} : '0)
            - {{(CREDIT_BITS+1){1'b0}}, dec};
        credits_d = (sum > {2'b00, INIT_CREDITS}) ? INIT_CREDITS : sum[CREDIT_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q <= INIT_CREDITS;
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits    = credits_q;
    assign has_credit = (credits_q != '0);

endmodule

// File: rtl/bft_stream_packetizer.sv
// Wraps an ap_vld/ap_ack word stream into BFT data packets to one fixed leaf/port.
// Latency: accept in cycle N -> packet on dout_pkt2bft in N+1; resend replays it in N+3.
// Backpressure: ack withheld when ap_start low, credits exhausted, or a replay is pending.
// Optional PACKETIZER_STATS_EN adds pkt_count / stall_count outputs.
module bft_stream_packetizer
    import bft_pkt_pkg::*;
#(
    parameter logic [NUM_LEAF_BITS-1:0] DEST_LEAF = 4'd0,
    parameter logic [NUM_PORT_BITS-1:0] DEST_PORT = 4'd2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic [PAYLOAD_BITS-1:0] din_user,
    input  logic                    vld_user2pkt,
    output logic                    ack_pkt2user,
    output logic [PACKET_BITS-1:0]  dout_pkt2bft,
    input  logic [PACKET_BITS-1:0]  din_bft2pkt,
    input  logic                    resend
`ifdef PACKETIZER_STATS_EN
    ,
    output logic [31:0]             pkt_count,
    output logic [31:0]             stall_count
`endif
);

    pkt_state_e               state_q, state_d;
    logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;
    logic [PACKET_BITS-1:0]   last_q, last_d;
    logic [CREDIT_BITS-1:0]   credits;
    logic                     has_credit;
    logic                     resend_eff;
    logic                     accept;
    logic                     credit_vld;
    logic                     unused_din_bits;

    // last_q holds whatever was on the wire one cycle ago: the packet a resend refers to.
    always_comb begin
        resend_eff = resend && last_q[VALID_BIT];
        accept     = ap_start && vld_user2pkt && has_credit && !resend_eff
                  && (state_q != ST_RESEND) && !reset;
        credit_vld = din_bft2pkt[VALID_BIT] && din_bft2pkt[CREDIT_FLAG_BIT];
        addr_d     = addr_q;
        dout_d     = '0;
        last_d     = dout_q;
        state_d    = ST_IDLE;
        if (resend_eff) begin
            dout_d  = last_q;
            state_d = ST_RESEND;
        end else if (accept) begin
            dout_d  = make_data_pkt(DEST_LEAF, DEST_PORT, addr_q, din_user);
            addr_d  = addr_q + NUM_ADDR_BITS'(1);
            state_d = ST_SENT;
        end else if (vld_user2pkt && !has_credit) begin
            state_d = ST_STALL;
        end
    end

    bft_credit_counter u_credit (
        .clk        (clk),
        .reset      (reset),
        .dec        (accept),
        .inc_vld    (credit_vld),
        .inc        (din_bft2pkt[CREDIT_BITS-1:0]),
        .credits    (credits),
        .has_credit (has_credit)
    );

    assign unused_din_bits = ^{din_bft2pkt[LEAF_MSB:ADDR_LSB],
                               din_bft2pkt[PAYLOAD_BITS-1:CREDIT_BITS]};

`ifdef PACKETIZER_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        pkt_count_d   = pkt_count_q + (accept ? 32'd1 : 32'd0);
        stall_count_d = stall_count_q;
        if ((state_q == ST_STALL) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    assign pkt_count   = pkt_count_q;
    assign stall_count = stall_count_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            dout_q        <= '0;
            last_q        <= '0;
`ifdef PACKETIZER_STATS_EN
            pkt_count_q   <= '0;
            stall_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            last_q        <= last_d;
`ifdef PACKETIZER_STATS_EN
            pkt_count_q   <= pkt_count_d;
            stall_count_q <= stall_count_d;
`endif
        end
    end

    assign ack_pkt2user = accept;
    assign dout_pkt2bft = dout_q;

endmodule

// File: tb/tb_bft_stream_packetizer.sv
// Directed bench for bft_stream_packetizer: reset, single word, credit stall/refill,
// resend replay, address wrap, credit saturation and reset during a replay.
module tb_bft_stream_packetizer;
    import bft_pkt_pkg::*;

    logic        clk;
    logic        reset;
    logic        ap_start;
    logic [31:0] din_user;
    logic        vld_user2pkt;
    logic        ack_pkt2user;
    logic [48:0] dout_pkt2bft;
    logic [48:0] din_bft2pkt;
    logic        resend;
`ifdef PACKETIZER_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] stall_count;
`endif

    bft_stream_packetizer dut (
        .clk          (clk),
        .reset        (reset),
        .ap_start     (ap_start),
        .din_user     (din_user),
        .vld_user2pkt (vld_user2pkt),
        .ack_pkt2user (ack_pkt2user),
        .dout_pkt2bft (dout_pkt2bft),
        .din_bft2pkt  (din_bft2pkt),
        .resend       (resend)
`ifdef PACKETIZER_STATS_EN
        ,
        .pkt_count    (pkt_count),
        .stall_count  (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          widx;
    int          nwords;
    int          acc_cnt;
    int          pkt_bad;
    logic [6:0]  exp_addr;
    logic [48:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [48:0] exp_pkt(input logic [6:0] addr, input logic [31:0] data);
        exp_pkt = {1'b1, 4'd0, 4'd2, addr, 1'b0, data};
    endfunction

    function automatic logic [48:0] credit_pkt(input logic flag, input logic [7:0] val);
        credit_pkt = {1'b1, 4'd0, 4'd0, 7'd0, flag, 24'd0, val};
    endfunction

    function automatic logic [31:0] word_of(input int i);
        word_of = 32'hC0DE_0000 + 32'(i);
    endfunction

    // One cycle of a well-behaved producer; every valid output is matched in order.
    task automatic run_cycle();
        logic acc_now;
        @(negedge clk);
        if (dout_pkt2bft[48]) begin
            if (exp_q.size() == 0) begin
                pkt_bad++;
            end else begin
                if (dout_pkt2bft !== exp_q[0]) pkt_bad++;
                void'(exp_q.pop_front());
            end
        end
        acc_now = ack_pkt2user;
        if (acc_now) begin
            exp_q.push_back(exp_pkt(exp_addr, din_user));
            exp_addr++;
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        if (acc_now) widx++;
        vld_user2pkt = (widx < nwords);
        din_user     = word_of(widx);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        vld_user2pkt = 1'b0;
        resend       = 1'b0;
        din_bft2pkt  = '0;
        ap_start     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_q.delete();
        exp_addr = '0;
        widx     = 0;
        nwords   = 0;
        acc_cnt  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; pkt_bad = 0;
        reset = 1'b1; ap_start = 1'b0; din_user = '0; vld_user2pkt = 1'b0;
        din_bft2pkt = '0; resend = 1'b0;

        // Reset values and a single word
        do_reset();
        @(negedge clk);
        chk("rst_dout", dout_pkt2bft, 49'd0);
        chk("rst_ack", ack_pkt2user, 1'b0);
        chk("rst_credits", dut.credits, 8'd128);
        chk("rst_addr", dut.addr_q, 7'd0);
        @(posedge clk); #1;
        ap_start = 1'b0; vld_user2pkt = 1'b1; din_user = 32'hDEADBEEF;
        @(negedge clk);
        chk("apstart_low_ack", ack_pkt2user, 1'b0);
        @(posedge clk); #1;
        ap_start = 1'b1;
        @(negedge clk);
        chk("single_ack", ack_pkt2user, 1'b1);
        @(posedge clk); #1;
        vld_user2pkt = 1'b0;
        @(negedge clk);
        chk("single_pkt", dout_pkt2bft, 49'h1_0200_DEAD_BEEF);
        chk("single_credits", dut.credits, 8'd127);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_one_cycle", dout_pkt2bft[48], 1'b0);

        // Exhaust credits, stall, refill by 64; addresses wrap 127 -> 0
        do_reset();
        nwords = 194; vld_user2pkt = 1'b1; din_user = word_of(0);
        repeat (132) run_cycle();
        chk("stall_accepts", acc_cnt, 128);
        chk("stall_ack", ack_pkt2user, 1'b0);
        chk("stall_state", 64'(dut.state_q), 64'(ST_STALL));
        chk("stall_credits", dut.credits, 8'd0);
        din_bft2pkt = credit_pkt(1'b0, 8'd50);
        run_cycle();
        din_bft2pkt = '0;
        run_cycle();
        chk("data_pkt_ignored", dut.credits, 8'd0);
        din_bft2pkt = credit_pkt(1'b1, 8'd64);
        run_cycle();
        din_bft2pkt = '0;
        repeat (70) run_cycle();
        chk("refill_accepts", acc_cnt, 192);
        chk("words_remaining", nwords - widx, 2);
        chk("refill_credits", dut.credits, 8'd0);
        chk("refill_ack", ack_pkt2user, 1'b0);
        chk("wrap_addr", dut.addr_q, 7'd64);
        chk("stream_pkts", pkt_bad, 0);
        chk("stream_drained", exp_q.size(), 0);

        // Resend of the packet with address 5
        do_reset();
        nwords = 5; vld_user2pkt = 1'b1; din_user = word_of(0);
        repeat (6) run_cycle();
        vld_user2pkt = 1'b1; din_user = 32'hA5A5_0005;
        @(negedge clk);
        chk("rs_ack5", ack_pkt2user, 1'b1);
        @(posedge clk); #1;
        vld_user2pkt = 1'b0;
        @(negedge clk);
        chk("rs_pkt5", dout_pkt2bft, exp_pkt(7'd5, 32'hA5A5_0005));
        chk("rs_credits_a", dut.credits, 8'd122);
        @(posedge clk); #1;
        resend = 1'b1; vld_user2pkt = 1'b1; din_user = 32'h1234_5678;
        @(negedge clk);
        chk("rs_no_ack_n2", ack_pkt2user, 1'b0);
        chk("rs_gap_n2", dout_pkt2bft[48], 1'b0);
        @(posedge clk); #1;
        resend = 1'b0;
        @(negedge clk);
        chk("rs_replay", dout_pkt2bft, exp_pkt(7'd5, 32'hA5A5_0005));
        chk("rs_no_ack_n3", ack_pkt2user, 1'b0);
        chk("rs_credits_b", dut.credits, 8'd122);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rs_ack6", ack_pkt2user, 1'b1);
        @(posedge clk); #1;
        vld_user2pkt = 1'b0;
        @(negedge clk);
        chk("rs_pkt6", dout_pkt2bft, exp_pkt(7'd6, 32'h1234_5678));
        chk("rs_credits_c", dut.credits, 8'd121);

        // Credit return of 64 in the same cycle as a send at credits=100
        do_reset();
        nwords = 29; vld_user2pkt = 1'b1; din_user = word_of(0);
        repeat (28) run_cycle();
        chk("sat_pre_credits", dut.credits, 8'd100);
        din_bft2pkt = credit_pkt(1'b1, 8'd64);
        run_cycle();
        din_bft2pkt = '0;
        chk("sat_send", acc_cnt, 29);
        chk("sat_credits", dut.credits, 8'd128);
        chk("sat_stream_pkts", pkt_bad, 0);

        // Reset while a replay is on the wire
        do_reset();
        vld_user2pkt = 1'b1; din_user = 32'h0BAD_F00D;
        @(negedge clk);
        chk("rr_ack", ack_pkt2user, 1'b1);
        @(posedge clk); #1;
        vld_user2pkt = 1'b0;
        @(posedge clk); #1;
        resend = 1'b1;
        @(posedge clk); #1;
        resend = 1'b0; reset = 1'b1; vld_user2pkt = 1'b1;
        @(negedge clk);
        chk("rr_replay", dout_pkt2bft, exp_pkt(7'd0, 32'h0BAD_F00D));
        chk("rr_ack_in_reset", ack_pkt2user, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; vld_user2pkt = 1'b0;
        @(negedge clk);
        chk("rr_dout", dout_pkt2bft, 49'd0);
        chk("rr_credits", dut.credits, 8'd128);
        chk("rr_addr", dut.addr_q, 7'd0);
        chk("rr_state", 64'(dut.state_q), 64'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
